// File: rtl/multiport_register_file_pkg.sv
// Purpose: shared constants and FSM state encoding for the multiport register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multiport_register_file_pkg;

  // Default geometry used by the CPU top when it does not override the parameters.
  localparam int RF_DEF_WIDTH = 32;
  localparam int RF_DEF_DEPTH = 32;

  // Clear sequencer states.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/multiport_register_file_clear_ctrl.sv
// Purpose: post-reset clear sequencer; walks every entry once and zeroes it.
// Latency: DEPTH clock edges from reset release to busy=0.
// Backpressure: busy=1 while clearing; the owner must drop writes during that time.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   busy         1 while the clear sequence runs
//   clr_en       1 when the entry at clr_addr must be zeroed at this edge
//   clr_addr     entry being cleared
module multiport_register_file_clear_ctrl
  import multiport_register_file_pkg::*;
#(
  parameter int DEPTH = RF_DEF_DEPTH,
  parameter int AW    = $clog2(RF_DEF_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     r_state;
  rf_state_e     w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b0;
    clr_en      = 1'b0;
    clr_addr    = r_cnt;
    case (r_state)
      RF_CLEAR: begin
        busy = 1'b1;
        // An edge with reset high restarts the walk, so no clear happens on it.
        clr_en    = !reset;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == AW'(DEPTH - 1)) begin
          w_state_nxt = RF_READY;
          w_cnt_nxt   = '0;
        end
      end
      RF_READY: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multiport_register_file.sv
// Purpose: DEPTH x WIDTH register file, NUM_RD combinational reads, two sync writes.
// Latency: reads zero-cycle (optional same-cycle write bypass); writes land at the edge.
// Backpressure: none on reads; writes silently dropped while busy (post-reset clear).
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   wen0/waddr0/wdata0      write port 0
//   wen1/waddr1/wdata1      write port 1, wins over port 0 on the same address
//   raddr / rdata           packed read ports, port k at [k*AW +: AW] / [k*WIDTH +: WIDTH]
//   busy                    1 while the clear sequence runs
module multiport_register_file
  import multiport_register_file_pkg::*;
#(
  parameter int WIDTH    = RF_DEF_WIDTH,
  parameter int DEPTH    = RF_DEF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wen0,
  input  logic [AW-1:0]           waddr0,
  input  logic [WIDTH-1:0]        wdata0,
  input  logic                    wen1,
  input  logic [AW-1:0]           waddr1,
  input  logic [WIDTH-1:0]        wdata1,
  input  logic [NUM_RD*AW-1:0]    raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  output logic                    busy
);

  // When DEPTH is a power of two every address is in range.
  localparam bit POW2 = (DEPTH == (1 << AW));

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic          w_busy;
  logic          w_clr_en;
  logic [AW-1:0] w_clr_addr;
  logic          w_wr0_ok;
  logic          w_wr1_ok;

  // Address is backed by real storage: in range and not the hardwired-zero entry.
  function automatic logic addr_live(input logic [AW-1:0] a);
    logic in_range;
    in_range = POW2 || (int'(a) < DEPTH);
    return in_range && !((ZERO_REG != 0) && (a == '0));
  endfunction

  multiport_register_file_clear_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_ctrl (
    .clk      (clk),
    .reset    (reset),
    .busy     (w_busy),
    .clr_en   (w_clr_en),
    .clr_addr (w_clr_addr)
  );

  assign busy = w_busy;

  // Effective write enables; bypass uses the same qualification so a read never
  // forwards data that will not be stored.
  assign w_wr0_ok = wen0 && !w_busy && !reset && addr_live(waddr0);
  assign w_wr1_ok = wen1 && !w_busy && !reset && addr_live(waddr1);

  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (w_wr0_ok && !(w_wr1_ok && (waddr1 == waddr0))) begin
        r_mem[waddr0] <= wdata0;
      end
      if (w_wr1_ok) begin
        r_mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_rd;

    assign w_ra = raddr[k*AW +: AW];

    always_comb begin
      w_rd = r_mem[w_ra];
      if (BYPASS != 0) begin
        if (w_wr1_ok && (waddr1 == w_ra)) begin
          w_rd = wdata1;
        end else if (w_wr0_ok && (waddr0 == w_ra)) begin
          w_rd = wdata0;
        end
      end
      // Busy, out-of-range and hardwired-zero reads take priority over bypass.
      if (w_busy || !addr_live(w_ra)) begin
        w_rd = '0;
      end
    end

    assign rdata[k*WIDTH +: WIDTH] = w_rd;
  end

endmodule
